// File: rtl/reg_file_clr.sv
// reg_file_clr: WIDTH x 2**ADDR_W register file (r0 reads zero) with async reset and a hardware clear sequencer; optional macro REGFILE_BYPASS_EN.
// Latency: reads combinational, writes commit on the next rising edge; clear = NREGS-1 busy cycles then a one-cycle done pulse.
// Backpressure: none; writes presented while busy/done are dropped and flagged by a one-cycle wr_drop pulse on the following cycle.
module reg_file_clr #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wd,
    input  logic              regwrite,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              wr_drop
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  regs [NREGS];

    // A write is only committed from IDLE; address 0 is never a real write,
    // so it is neither committed nor reported as dropped.
    logic wr_accept;
    logic wr_refuse;

    assign wr_accept = regwrite && (wr != '0) && (state == IDLE);
    assign wr_refuse = regwrite && (wr != '0) && (state != IDLE);

    // Clear sequencer: IDLE -> CLEAR walks ptr 1..NREGS-1 -> DONE -> IDLE.
    // ptr is parked at 1 on exit so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= PTR_FIRST;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= PTR_FIRST;
                    end
                end
                CLEAR: begin
                    if (ptr == PTR_LAST) begin
                        state <= DONE;
                        ptr   <= PTR_FIRST;
                    end else begin
                        ptr <= ptr + PTR_FIRST;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= PTR_FIRST;
                end
                default: begin
                    state <= IDLE;
                    ptr   <= PTR_FIRST;
                end
            endcase
        end
    end

    // Status decoded straight from the registered state.
    assign busy = (state == CLEAR);
    assign done = (state == DONE);

    // Refused-write flag, one cycle after the refused edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_refuse;
        end
    end

    // Storage: the sequencer zeroes one entry per cycle; normal writes only
    // happen in IDLE so the two never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else if (wr_accept) begin
            regs[wr] <= wd;
        end
    end

    // Read ports: address 0 is forced to zero; with forwarding enabled an
    // accepted write is visible on a matching port in the same cycle.
    always_comb begin
        rd1 = (rr1 == '0) ? '0 : regs[rr1];
        rd2 = (rr2 == '0) ? '0 : regs[rr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (rr1 == wr)) begin
            rd1 = wd;
        end
        if (wr_accept && (rr2 == wr)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_clr.sv
// Bench for reg_file_clr (WIDTH=16, ADDR_W=2): reads checked through a
// queue of expected values taken from a small reference array of the file.
// Inputs are driven 1ns after the rising edge and outputs sampled before the next.
module tb_reg_file_clr;

    logic        clock;
    logic        reset;
    logic [1:0]  rr1;
    logic [1:0]  rr2;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        regwrite;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        clear;
    logic        busy;
    logic        done;
    logic        wr_drop;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [4];
    logic [15:0] exp_q [$];

    reg_file_clr #(.WIDTH(16), .ADDR_W(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .rr1      (rr1),
        .rr2      (rr2),
        .wr       (wr),
        .wd       (wd),
        .regwrite (regwrite),
        .rd1      (rd1),
        .rd2      (rd2),
        .clear    (clear),
        .busy     (busy),
        .done     (done),
        .wr_drop  (wr_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_reads(input int a, input int b);
        rr1 = 2'(a);
        rr2 = 2'(b);
        exp_q.push_back(model[a]);
        exp_q.push_back(model[b]);
    endtask

    // Single IDLE write; the model only changes for a non-zero address.
    task automatic do_write(input int a, input logic [15:0] d);
        regwrite = 1'b1;
        wr = 2'(a);
        wd = d;
        tick();
        regwrite = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset = 1'b1; clear = 1'b0; regwrite = 1'b0;
        rr1 = '0; rr2 = '0; wr = '0; wd = '0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (2) tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b wr_drop=%b expected 0 0 0", busy, done, wr_drop);
        end
        for (int a = 0; a < 4; a++) begin
            drive_reads(a, 3 - a);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (rd1 !== e) begin
                n_fail++;
                $display("FAIL reset_rd1[%0d]: got %h expected %h", a, rd1, e);
            end
            e = exp_q.pop_front();
            n_tests++;
            if (rd2 !== e) begin
                n_fail++;
                $display("FAIL reset_rd2[%0d]: got %h expected %h", 3 - a, rd2, e);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [15:0] e;
        do_write(1, 16'h000F);
        do_write(2, 16'h0007);
        drive_reads(1, 2);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL write_rd1: got %h expected %h", rd1, e);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (rd2 !== e) begin
            n_fail++;
            $display("FAIL write_rd2: got %h expected %h", rd2, e);
        end
        drive_reads(0, 1);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL write_rd_addr0: got %h expected %h", rd1, e);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_addr0_write();
        logic [15:0] e;
        do_write(0, 16'hFFFF);
        n_tests++;
        if (wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL addr0_wr_drop: got %b expected 0", wr_drop);
        end
        drive_reads(0, 0);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL addr0_rd1: got %h expected %h", rd1, e);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (rd2 !== e) begin
            n_fail++;
            $display("FAIL addr0_rd2: got %h expected %h", rd2, e);
        end
    endtask

    task automatic test_clear();
        logic [15:0] e;
        do_write(1, 16'h0001);
        do_write(2, 16'h0002);
        do_write(3, 16'h0003);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_busy[%0d]: busy=%b done=%b expected 1 0", k, busy, done);
            end
            tick();
            model[k] = '0;
            drive_reads(k, (k < 3) ? k + 1 : 0);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (rd1 !== e) begin
                n_fail++;
                $display("FAIL clear_zeroed[%0d]: got %h expected %h", k, rd1, e);
            end
            e = exp_q.pop_front();
            n_tests++;
            if (rd2 !== e) begin
                n_fail++;
                $display("FAIL clear_pending[%0d]: got %h expected %h", k, rd2, e);
            end
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: done=%b busy=%b expected 1 0", done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_drop();
        logic [15:0] e;
        int cnt;
        do_write(2, 16'h2222);
        do_write(3, 16'hAAAA);
        clear = 1'b1;
        tick();
        // First busy cycle: write and a repeat clear request both presented.
        regwrite = 1'b1; wr = 2'd3; wd = 16'h1234;
        tick();
        regwrite = 1'b0; clear = 1'b0;
        n_tests++;
        if (wr_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pulse: wr_drop=%b expected 1", wr_drop);
        end
        tick();
        n_tests++;
        if (wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_single: wr_drop=%b expected 0", wr_drop);
        end
        cnt = 0;
        while (done !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_done_seen: done=%b expected 1 within 10 cycles", done);
        end
        // DONE cycle: write must drop, clear must not restart the sequence.
        regwrite = 1'b1; wr = 2'd2; wd = 16'h5555; clear = 1'b1;
        tick();
        regwrite = 1'b0; clear = 1'b0;
        n_tests++;
        if (wr_drop !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_in_done: wr_drop=%b busy=%b expected 1 0", wr_drop, busy);
        end
        for (int i = 1; i < 4; i++) model[i] = '0;
        drive_reads(3, 2);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL drop_r3: got %h expected %h", rd1, e);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (rd2 !== e) begin
            n_fail++;
            $display("FAIL drop_r2: got %h expected %h", rd2, e);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [15:0] e;
        int pulses;
        int cnt;
        int busy_cnt;
        do_write(1, 16'h0011);
        do_write(2, 16'h0022);
        do_write(3, 16'h0033);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_status: busy=%b done=%b expected 0 0", busy, done);
        end
        for (int i = 0; i < 4; i++) model[i] = '0;
        drive_reads(2, 3);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL abort_r2: got %h expected %h", rd1, e);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (rd2 !== e) begin
            n_fail++;
            $display("FAIL abort_r3: got %h expected %h", rd2, e);
        end
        repeat (2) tick();
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: saw %0d done pulses expected 0", pulses);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy_cnt = 0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cnt++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reclear_done: done=%b expected 1 within 20 cycles", done);
        end
        n_tests++;
        if (busy_cnt != 3) begin
            n_fail++;
            $display("FAIL reclear_busy_len: got %0d busy cycles expected 3", busy_cnt);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [15:0] e;
        logic [15:0] fwd;
        int cnt;
        do_write(1, 16'h0005);
`ifdef REGFILE_BYPASS_EN
        fwd = 16'h0009;
`else
        fwd = 16'h0005;
`endif
        rr1 = 2'd1;
        regwrite = 1'b1; wr = 2'd1; wd = 16'h0009;
        exp_q.push_back(fwd);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL bypass_before_edge: got %h expected %h", rd1, e);
        end
        tick();
        regwrite = 1'b0;
        model[1] = 16'h0009;
        exp_q.push_back(model[1]);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (rd1 !== e) begin
            n_fail++;
            $display("FAIL bypass_after_edge: got %h expected %h", rd1, e);
        end
        // A write refused during clear must never appear on a read port.
        do_write(3, 16'h0C0C);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive_reads(1, 3);
        regwrite = 1'b1; wr = 2'd3; wd = 16'hBEEF;
        #1;
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        n_tests++;
        if (rd2 !== e) begin
            n_fail++;
            $display("FAIL bypass_no_fwd_drop: got %h expected %h", rd2, e);
        end
        regwrite = 1'b0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_clear_done: done=%b expected 1 within 10 cycles", done);
        end
        tick();
        for (int i = 1; i < 4; i++) model[i] = '0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr0_write();
        test_clear();
        test_drop();
        test_reset_mid_clear();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
